// File: rtl/div_pkg.sv
// Shared types and helpers for the iterative RV32M divider.
package div_pkg;

  typedef enum logic [1:0] {
    DIV  = 2'd0,
    DIVU = 2'd1,
    REM  = 2'd2,
    REMU = 2'd3
  } div_op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    FINAL = 2'd2
  } div_state_t;

  function automatic logic is_signed_op(input div_op_t op);
    return (op == DIV) || (op == REM);
  endfunction

  function automatic logic is_rem_op(input div_op_t op);
    return (op == REM) || (op == REMU);
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {rem,quo} left, trial-subtract divisor.
module div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic [WIDTH-1:0] quo_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic [WIDTH-1:0] quo_out
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // rem < divisor always holds, so the true difference fits and bit WIDTH is its sign
  always_comb begin
    shifted = {rem_in, quo_in[WIDTH-1]};
    diff    = shifted - {1'b0, divisor};
    if (!diff[WIDTH]) begin
      rem_out = diff[WIDTH-1:0];
      quo_out = {quo_in[WIDTH-2:0], 1'b1};
    end else begin
      rem_out = shifted[WIDTH-1:0];
      quo_out = {quo_in[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/div_unit.sv
// Iterative RV32M DIV/DIVU/REM/REMU unit, one restoring step per clock.
// Define DIV_EARLY_EXIT_EN to complete divide-by-zero and signed overflow in one cycle.
module div_unit
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ALL_ONES = '1;

  div_state_t       state;
  div_op_t          op_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] dvs_q;
  logic [WIDTH-1:0] dividend_q;
  logic             neg_quo_q;
  logic             neg_rem_q;
  logic             dz_q;
  logic             ovf_q;

  div_op_t          op_in;
  logic             sgn_in;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic             dz_in;
  logic             ovf_in;
  logic [WIDTH-1:0] rem_nx;
  logic [WIDTH-1:0] quo_nx;
  logic [WIDTH-1:0] final_res;

  // Operand decode at the accepting edge
  always_comb begin
    op_in  = div_op_t'(op);
    sgn_in = is_signed_op(op_in);
    a_neg  = sgn_in & dividend[WIDTH-1];
    b_neg  = sgn_in & divisor[WIDTH-1];
    a_mag  = a_neg ? -dividend : dividend;
    b_mag  = b_neg ? -divisor : divisor;
    dz_in  = (divisor == '0);
    ovf_in = sgn_in && (dividend == MIN_NEG) && (divisor == ALL_ONES);
  end

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  (rem_q),
    .quo_in  (quo_q),
    .divisor (dvs_q),
    .rem_out (rem_nx),
    .quo_out (quo_nx)
  );

  // Architectural result, with special cases overriding the iterated value
  always_comb begin
    final_res = '0;
    if (dz_q) begin
      final_res = is_rem_op(op_q) ? dividend_q : ALL_ONES;
    end else if (ovf_q) begin
      final_res = is_rem_op(op_q) ? '0 : dividend_q;
    end else if (is_rem_op(op_q)) begin
      final_res = neg_rem_q ? -rem_q : rem_q;
    end else begin
      final_res = neg_quo_q ? -quo_q : quo_q;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      result     <= '0;
      op_q       <= DIV;
      cnt_q      <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      dvs_q      <= '0;
      dividend_q <= '0;
      neg_quo_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      dz_q       <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            op_q       <= op_in;
            rem_q      <= '0;
            quo_q      <= a_mag;
            dvs_q      <= b_mag;
            dividend_q <= dividend;
            neg_quo_q  <= a_neg ^ b_neg;
            neg_rem_q  <= a_neg;
            dz_q       <= dz_in;
            ovf_q      <= ovf_in;
            cnt_q      <= CNT_W'(WIDTH - 1);
            busy       <= 1'b1;
`ifdef DIV_EARLY_EXIT_EN
            state      <= (dz_in || ovf_in) ? FINAL : CALC;
`else
            state      <= CALC;
`endif
          end
        end
        CALC: begin
          rem_q <= rem_nx;
          quo_q <= quo_nx;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == '0) state <= FINAL;
        end
        FINAL: begin
          result <= final_res;
          done   <= 1'b1;
          busy   <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed vector table, corner sequences, random ops vs a model.
module tb_div_unit;

  localparam int unsigned W = 32;

  logic          clock = 1'b0;
  logic          reset;
  logic          start;
  logic [1:0]    op;
  logic [W-1:0]  dividend;
  logic [W-1:0]  divisor;
  logic          busy;
  logic          done;
  logic [W-1:0]  result;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  div_unit #(.WIDTH(W)) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .dividend (dividend),
    .divisor  (divisor),
    .busy     (busy),
    .done     (done),
    .result   (result)
  );

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[14];

  // RISC-V division semantics straight from the ISA rules
  function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    logic               is_rem;
    logic               is_signed;
    sa        = a;
    sb        = b;
    is_rem    = o[1];
    is_signed = !o[0];
    if (b == 32'd0) return is_rem ? a : 32'hFFFF_FFFF;
    if (is_signed && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return is_rem ? 32'd0 : a;
    if (is_signed) return is_rem ? 32'(sa % sb) : 32'(sa / sb);
    return is_rem ? a % b : a / b;
  endfunction

  function automatic int exp_lat(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    logic special;
    special = (b == 32'd0) || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
`ifdef DIV_EARLY_EXIT_EN
    return special ? 1 : W + 1;
`else
    return (special) ? W + 1 : W + 1;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at a negedge; start is seen by the next rising edge (edge 0)
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    start    = 1'b1;
    op       = o;
    dividend = a;
    divisor  = b;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
  endtask

  // Returns at the negedge where done is high; lat counts rising edges after edge 0
  task automatic wait_done(output logic [31:0] res, output int lat, output bit held);
    lat  = 0;
    held = 1'b1;
    while (!done && lat < 100) begin
      if (!busy) held = 1'b0;
      @(posedge clock);
      lat++;
      @(negedge clock);
    end
    res = result;
  endtask

  task automatic run_check(input string name, input logic [1:0] o, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp);
    logic [31:0] res;
    int          lat;
    bit          held;
    issue(o, a, b);
    wait_done(res, lat, held);
    chk({name, " result"}, res, exp);
    chk({name, " latency"}, 32'(lat), 32'(exp_lat(o, a, b)));
    chk({name, " busy_at_done"}, 32'(busy), 32'd0);
    chk({name, " busy_held"}, 32'(held), 32'd1);
    @(negedge clock);
    chk({name, " done_pulse"}, 32'(done), 32'd0);
  endtask

  task automatic watch_quiet(input string name, input int n);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      if (done) seen = 1'b1;
    end
    chk(name, 32'(seen), 32'd0);
  endtask

  initial begin
    logic [31:0] res;
    logic [31:0] specials[6];
    logic [31:0] ra;
    logic [31:0] rb;
    logic [1:0]  ro;
    int          lat;
    bit          held;

    vecs[0]  = '{"divu_100_7",   2'd1, 32'd100,        32'd7,          32'd14};
    vecs[1]  = '{"remu_100_7",   2'd3, 32'd100,        32'd7,          32'd2};
    vecs[2]  = '{"div_m7_2",     2'd0, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD};
    vecs[3]  = '{"rem_m7_2",     2'd2, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF};
    vecs[4]  = '{"div_7_m2",     2'd0, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD};
    vecs[5]  = '{"rem_7_m2",     2'd2, 32'd7,          32'hFFFF_FFFE,  32'd1};
    vecs[6]  = '{"div_5_0",      2'd0, 32'd5,          32'd0,          32'hFFFF_FFFF};
    vecs[7]  = '{"remu_5_0",     2'd3, 32'd5,          32'd0,          32'd5};
    vecs[8]  = '{"div_ovf",      2'd0, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000};
    vecs[9]  = '{"rem_ovf",      2'd2, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0};
    vecs[10] = '{"divu_max_1",   2'd1, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF};
    vecs[11] = '{"rem_0_0",      2'd2, 32'd0,          32'd0,          32'd0};
    vecs[12] = '{"divu_ovfpat",  2'd1, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0};
    vecs[13] = '{"div_m8_m3",    2'd0, 32'hFFFF_FFF8,  32'hFFFF_FFFD,  32'd2};

    specials[0] = 32'd0;
    specials[1] = 32'd1;
    specials[2] = 32'hFFFF_FFFF;
    specials[3] = 32'h8000_0000;
    specials[4] = 32'd7;
    specials[5] = 32'hFFFF_FFF9;

    reset    = 1'b1;
    start    = 1'b0;
    op       = 2'd0;
    dividend = '0;
    divisor  = '0;
    repeat (3) @(negedge clock);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset result", result, 32'd0);
    reset = 1'b0;
    @(negedge clock);

    for (int i = 0; i < 14; i++)
      run_check(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp);

    // start while busy is dropped
    issue(2'd1, 32'd100, 32'd7);
    repeat (3) @(negedge clock);
    start = 1'b1; op = 2'd0; dividend = 32'd5; divisor = 32'd0;
    @(negedge clock);
    start = 1'b0;
    wait_done(res, lat, held);
    chk("ignored_start result", res, 32'd14);
    chk("ignored_start latency", 32'(lat + 4), 32'(W + 1));
    watch_quiet("ignored_start no_second_done", 40);

    // start coincident with done is accepted
    issue(2'd1, 32'd100, 32'd7);
    wait_done(res, lat, held);
    chk("b2b first result", res, 32'd14);
    issue(2'd1, 32'd9, 32'd3);
    wait_done(res, lat, held);
    chk("b2b second result", res, 32'd3);
    chk("b2b second latency", 32'(lat), 32'(W + 1));
    @(negedge clock);

    // reset at edge 10 aborts the operation
    issue(2'd1, 32'd100, 32'd7);
    repeat (9) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort done", 32'(done), 32'd0);
    chk("abort result", result, 32'd0);
    reset = 1'b0;
    watch_quiet("abort no_done", 40);
    run_check("after_abort", 2'd0, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);

    for (int i = 0; i < 200; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 5)] : $urandom();
      rb = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 5)]
                                       : ($urandom() >> $urandom_range(0, 31));
      run_check($sformatf("rand%0d op%0d %h/%h", i, ro, ra, rb), ro, ra, rb, model(ro, ra, rb));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
